// File: rtl/full_adder_pkg.sv
// Shared constants and the arithmetic reference for the registered ripple adder.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    // Reference {carry, sum} of a + b + cin, with the operands truncated to width bits.
    function automatic logic [FA_MAX_WIDTH:0] fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin,
        input int                      width
    );
        logic [FA_MAX_WIDTH-1:0] mask;
        mask = (width >= FA_MAX_WIDTH) ? '1
                                       : ((FA_MAX_WIDTH'(1) << width) - FA_MAX_WIDTH'(1));
        return {1'b0, a & mask} + {1'b0, b & mask} + {{FA_MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One combinational full-adder bit; the top chains these into a ripple adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {Cout, Sum} = A + B + Cin, one cycle of latency.
// Optional macro FULL_ADDER_OVF_EN adds a registered two's-complement overflow flag Ovf.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    // carry[0] is the carry in; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = Cin;

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a     (A[i]),
            .b     (B[i]),
            .c_in  (carry[i]),
            .s     (sum_c[i]),
            .c_out (carry[i+1])
        );
    end

    // Output register: reload the ripple result every cycle, clear while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= sum_c;
            Cout <= carry[WIDTH];
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carries into and out of the MSB disagree; same stage as Sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            Ovf <= 1'b0;
        end else begin
            Ovf <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end
`endif

    // Registered result must match plain arithmetic on the previous edge's inputs.
    a_ref_sum : assert property (@(posedge clk)
        !rst |=> {Cout, Sum} == (WIDTH+1)'(fa_ref(FA_MAX_WIDTH'($past(A)),
                                                  FA_MAX_WIDTH'($past(B)),
                                                  $past(Cin), WIDTH)))
        else $warning("full_adder: registered result differs from reference");

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH = 1, 8 and 64 in parallel.
module tb_full_adder;
    import full_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        a1, b1, cin1, s1, co1;
    logic [7:0]  a8, b8, s8;
    logic        cin8, co8;
    logic [63:0] a64, b64, s64;
    logic        cin64, co64;
`ifdef FULL_ADDER_OVF_EN
    logic        o1, o8, o64;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .Sum(s1), .Cout(co1)
`ifdef FULL_ADDER_OVF_EN
        , .Ovf(o1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .Sum(s8), .Cout(co8)
`ifdef FULL_ADDER_OVF_EN
        , .Ovf(o8)
`endif
    );

    full_adder #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .A(a64), .B(b64), .Cin(cin64), .Sum(s64), .Cout(co64)
`ifdef FULL_ADDER_OVF_EN
        , .Ovf(o64)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow from value ranges: true signed result outside the w-bit range.
    function automatic logic ovf_model(input logic [63:0] a, input logic [63:0] b,
                                       input logic cin, input int w);
        logic signed [65:0] sa, sb, s, lim;
        sa  = 66'($signed(a << (64 - w))) >>> (64 - w);
        sb  = 66'($signed(b << (64 - w))) >>> (64 - w);
        s   = sa + sb + $signed({65'b0, cin});
        lim = 66'sd1 <<< (w - 1);
        return (s >= lim) || (s < -lim);
    endfunction
`endif

    logic [1:0]  exp_tt [8];
    vec_t        vecs [7];
    logic [64:0] e1, e8, e64;
`ifdef FULL_ADDER_OVF_EN
    logic        eo1, eo8, eo64;
`endif

    initial begin
        exp_tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        vecs[0] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'h05, b: 8'hFB, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 8'h3C, b: 8'h0F, cin: 1'b1, sum: 8'h4C, cout: 1'b0, ovf: 1'b0};

        // Reset with non-zero inputs present: outputs must stay cleared.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        a64 = '1; b64 = '1; cin64 = 1'b1;
        step();
        step();
        chk("reset_w1",  {63'b0, co1, s1}, 65'd0);
        chk("reset_w8",  {56'b0, co8, s8}, 65'd0);
        chk("reset_w64", {co64, s64},      65'd0);
`ifdef FULL_ADDER_OVF_EN
        chk("reset_ovf", {62'b0, o1, o8, o64}, 65'd0);
`endif

        // Exhaustive single-bit truth table.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            step();
            chk($sformatf("tt_%0d", i), {63'b0, co1, s1}, {63'b0, exp_tt[i]});
        end

        // Directed 8-bit vectors: ripple, full scale, overflow boundaries.
        for (int i = 0; i < 7; i++) begin
            a8 = vecs[i].a; b8 = vecs[i].b; cin8 = vecs[i].cin;
            step();
            chk($sformatf("vec_%0d", i), {56'b0, co8, s8}, {56'b0, vecs[i].cout, vecs[i].sum});
`ifdef FULL_ADDER_OVF_EN
            chk($sformatf("vec_ovf_%0d", i), {64'b0, o8}, {64'b0, vecs[i].ovf});
`endif
        end

        // Outputs come from flops: changing inputs mid-cycle must not move them.
        a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0;
        #2;
        chk("no_comb_path", {56'b0, co8, s8}, {56'b0, vecs[6].cout, vecs[6].sum});

        // Reset mid-stream with A=B=Cin=1 held on the single-bit slice.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        step();
        chk("pre_rst", {63'b0, co1, s1}, 65'd3);
        rst = 1'b1;
        step();
        chk("mid_rst_0", {63'b0, co1, s1}, 65'd0);
        step();
        chk("mid_rst_1", {63'b0, co1, s1}, 65'd0);
        rst = 1'b0;
        step();
        chk("post_rst", {63'b0, co1, s1}, 65'd3);

        // Random traffic on all three widths against plain arithmetic.
        for (int n = 0; n < 10000; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; cin64 = 1'($urandom);
            if (n % 16 == 0) begin
                a64 = (n % 32 == 0) ? '1 : '0;
                b64 = '1;
            end
            e1  = fa_ref(64'(a1), 64'(b1), cin1, 1);
            e8  = fa_ref(64'(a8), 64'(b8), cin8, 8);
            e64 = fa_ref(a64, b64, cin64, 64);
`ifdef FULL_ADDER_OVF_EN
            eo1  = ovf_model(64'(a1), 64'(b1), cin1, 1);
            eo8  = ovf_model(64'(a8), 64'(b8), cin8, 8);
            eo64 = ovf_model(a64, b64, cin64, 64);
`endif
            step();
            chk("rand_w1",  {63'b0, co1, s1}, e1);
            chk("rand_w8",  {56'b0, co8, s8}, e8);
            chk("rand_w64", {co64, s64},      e64);
`ifdef FULL_ADDER_OVF_EN
            chk("rand_ovf", {62'b0, o1, o8, o64}, {62'b0, eo1, eo8, eo64});
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry adder built from 1-bit full-adder cells.
- Computes Sum/Cout = A + B + Cin and registers the result on the clock.
- At the default WIDTH=1 it is the classic single-bit full adder with a one-cycle output register.
- Used as a datapath leaf wherever a carry-in/carry-out adder slice is needed.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  addend A (unsigned; two's-complement when overflow is read).
- B  input  WIDTH  addend B.
- Cin  input  1  carry in.
- Sum  output  WIDTH  registered sum bits.
- Cout  output  1  registered carry out of the MSB.
- Ovf  output  1  registered signed overflow; present only with FULL_ADDER_OVF_EN.

Behaviour:
- There is one clock domain. Reset is synchronous and active-high: clk and rst, with rst sampled only on the rising edge of clk.
- Reset values:
  - Sum = 0, Cout = 0, Ovf = 0.
  - Outputs hold 0 on every edge while rst = 1.
- Combinational core is a ripple chain of WIDTH cells.
  - Carry into cell 0 is Cin.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - Cout is c_WIDTH.
- Arithmetic: {Cout, Sum} = A + B + Cin, computed exactly in WIDTH+1 bits with no saturation.
- Latency is 1 cycle.
  - Inputs are sampled at rising edge N when rst = 0.
  - The result is visible on Sum/Cout after edge N and holds until edge N+1.
- There is no handshake. The block recomputes and reloads every cycle, and outputs always reflect the previous edge's inputs.
- Outputs are driven only from flops, never combinationally from inputs.
- Boundary cases:
  - All-ones + all-ones + 1 gives Sum = all-ones, Cout = 1.
  - All-ones + 0 + 1 wraps to Sum = 0, Cout = 1.
  - 0 + 0 + 0 gives all zeros.
- Reset mid-operation: the next edge with rst = 1 clears the outputs and drops the in-flight result. The first edge with rst = 0 loads the sum of the inputs present at that edge.
- X/Z on inputs is not handled; callers drive known values.

Optional Feature:
- Macro FULL_ADDER_OVF_EN.
- Defined:
  - Adds output Ovf, registered in the same flop stage as Sum.
  - Ovf = c_WIDTH ^ c_(WIDTH-1), i.e. two's-complement overflow.
  - For WIDTH=1, c_0 = Cin, so Ovf = Cout ^ Cin.
  - Reset value is 0.
- Undefined: no Ovf port and no extra flop. Sum/Cout behaviour is identical in both builds.

Decomposition:
- Package full_adder_pkg holds:
  - FA_MAX_WIDTH = 64, a localparam bound checked at elaboration; WIDTH outside 1..64 is an elaboration error.
  - A function fa_ref(a, b, cin) returning the WIDTH+1-bit reference sum, shared by RTL assertions and the bench scoreboard.
- Sub-module full_adder_cell: one combinational bit with inputs a, b, c_in and outputs s, c_out. It is instantiated WIDTH times in a generate loop.
- The top owns the carry vector, the output registers and the optional Ovf logic.

Test Plan:
- Exhaustive truth table: WIDTH=1, apply all 8 {A,B,Cin} combos from 000 to 111, one per cycle.
  - Expected {Cout,Sum}: 00, 01, 01, 10, 01, 10, 10, 11, each one cycle after application.
- Carry ripple: WIDTH=8, A=0xFF, B=0x00, Cin=1 -> next cycle Sum=0x00, Cout=1.
- Full-scale: WIDTH=8, A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1; then A=0x00, B=0x00, Cin=0 -> Sum=0x00, Cout=0.
- Overflow (FULL_ADDER_OVF_EN), WIDTH=8:
  - A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Cout=0, Ovf=1.
  - A=0x80, B=0x80, Cin=0 -> Sum=0x00, Cout=1, Ovf=1.
  - A=0x05, B=0xFB, Cin=0 -> Sum=0x00, Cout=1, Ovf=0.
- Reset mid-stream: hold A=B=1, Cin=1 (WIDTH=1) and assert rst for 2 cycles -> Sum=0, Cout=0 during reset. On the first edge after release -> Sum=1, Cout=1.
- Random: 10,000 cycles of random A/B/Cin at WIDTH=1, 8 and 64, each result checked against fa_ref with a 1-cycle delay.
